np_write_buffer: RTL and testbench
==================================

Name: np_write_buffer

Overview:
Posted-write buffer between the np core and the synchronous memory. It sits on the wr/address/data path.
- CPU stores are queued in a small FIFO and drained to memory when the memory port is free.
- CPU loads are forwarded from the FIFO on an address hit, otherwise passed through to memory.
- A flush handshake drains all pending stores before halt, so the memory image is complete when simulation ends.

Parameters:
WIDTH, 32, data width in bits.
ADDRSIZE, 12, word-address width.
DEPTH, 4, FIFO entries (power of 2, at least 2).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; clears all state
cpu_rd  in  1  load request this cycle
cpu_wr  in  1  store request this cycle
cpu_addr  in  ADDRSIZE  load/store word address
cpu_wdata  in  WIDTH  store data
cpu_rdata  out  WIDTH  load data, valid when cpu_rvalid=1
cpu_rvalid  out  1  load data valid (1 cycle after an accepted load)
cpu_stall  out  1  combinational; request this cycle not accepted, core must hold it
flush_req  in  1  level; drain FIFO and block new requests
flush_done  out  1  FIFO empty and flush in effect
mem_wr  out  1  memory write strobe
mem_addr  out  ADDRSIZE  memory address
mem_wdata  out  WIDTH  memory write data
mem_rdata  in  WIDTH  memory read data, valid 1 cycle after mem_addr with mem_wr=0
err  out  1  sticky; cpu_rd and cpu_wr seen together

Behaviour:
Reset:
- FIFO empty, FSM in RUN.
- cpu_rvalid=0, cpu_rdata=0, mem_wr=0, mem_addr=0, mem_wdata=0, flush_done=0, err=0.
- Reset mid-operation discards all queued stores; nothing is written to memory.

FIFO:
- Circular, DEPTH entries {addr, data}, head/tail pointers with wrap, count 0..DEPTH.
- full when count==DEPTH; empty when count==0.

Memory port arbitration (one access per cycle), in RUN:
- If full and a store is queued: drain has priority. A load miss stalls.
- Else a load miss owns the port: mem_addr=cpu_addr, mem_wr=0.
- Else drain the head: mem_wr=1, mem_addr/mem_wdata=head entry, pop at the clock edge.
- Else mem_wr=0.

Loads:
- Hit: cpu_addr matches a valid entry. Forward the youngest matching entry's data.
- Hit does not use the memory port, so a drain may proceed in the same cycle.
- An entry popped in the same cycle still counts as a hit.
- Miss: read from memory.
- Either way, cpu_rvalid=1 and cpu_rdata are valid exactly 1 cycle after acceptance. Fixed latency 1.
- cpu_rvalid is 0 in all other cycles. cpu_rdata holds its last value.

Stores:
- Accepted when not full, or when full and drain pops this cycle (push+pop, count unchanged).
- Otherwise cpu_stall=1.
- Stores to the same address are kept as separate entries and drained in order.

cpu_stall:
- Asserted if (cpu_wr and full and no pop this cycle), or (cpu_rd miss while drain has priority), or (cpu_rd or cpu_wr while FSM not in RUN).

Illegal request (cpu_rd and cpu_wr both 1):
- Treated as a load only; store dropped; err set, cleared only by reset.

FSM:
- RUN: flush_req=1 goes to FLUSH.
- FLUSH: drain one entry per cycle, no CPU accesses accepted. Go to DONE in the cycle count reaches 0. Entered with an empty FIFO, go to DONE on the next edge.
- DONE: flush_done=1. flush_req=0 returns to RUN (flush_done=0 from then).

Decomposition:
- Shared package np_pkg: WIDTH, ADDRSIZE, DEPTH defaults, and the FSM state encoding RUN/FLUSH/DONE (2-bit).
- One sub-module: np_wbuf_fifo. Storage, pointers, count, full/empty, and a parallel youngest-match address compare returning hit and data.
- Arbitration, stall, FSM and read-valid pipeline stay in np_write_buffer.

Test Plan:
1. Store 0x11111111 to addr 5, then load addr 5 next cycle. cpu_rvalid=1 one cycle later with 0x11111111. The forward is taken even if the entry drained in the load cycle.
2. Stores to 5 (0xA) then 5 (0xB), load 5 before drain. Returns 0xB; memory ends with addr 5 = 0xB after both drains, in order.
3. Load miss on addr 9 with FIFO empty and memory[9]=0xDEADBEEF. mem_addr=9, mem_wr=0; cpu_rvalid with 0xDEADBEEF 1 cycle later.
4. Five back-to-back stores with DEPTH=4 and concurrent loads starving drain. Full forces drain priority; fifth store stalls until the pop cycle, then is accepted; all five reach memory.
5. Three stores queued, then flush_req=1. CPU requests stalled; three mem_wr cycles; flush_done=1 on the next edge; flush_req=0 returns to RUN.
6. Reset with 2 entries queued, and cpu_rd+cpu_wr together before reset. After the reset cycle: no mem_wr, FIFO empty, err=0. Before the reset: err=1 and the store was dropped.

Source files
------------

// File: rtl/np_pkg.sv
// rtl/np_pkg.sv - shared defaults and FSM encoding for the np posted-write buffer
package np_pkg;

  localparam int NP_WIDTH    = 32;
  localparam int NP_ADDRSIZE = 12;
  localparam int NP_DEPTH    = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } np_state_t;

endpackage

// File: rtl/np_wbuf_fifo.sv
// rtl/np_wbuf_fifo.sv - circular store queue with youngest-match address lookup
module np_wbuf_fifo
  import np_pkg::*;
#(
  parameter int WIDTH    = NP_WIDTH,
  parameter int ADDRSIZE = NP_ADDRSIZE,
  parameter int DEPTH    = NP_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [ADDRSIZE-1:0] push_addr,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                pop,
  output logic [ADDRSIZE-1:0] head_addr,
  output logic [WIDTH-1:0]    head_data,
  output logic                full,
  output logic                empty,
  output logic                last,
  input  logic [ADDRSIZE-1:0] lookup_addr,
  output logic                hit,
  output logic [WIDTH-1:0]    hit_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDRSIZE-1:0] addr_q [DEPTH];
  logic [WIDTH-1:0]    data_q [DEPTH];
  logic [PW-1:0]       head_q;
  logic [PW-1:0]       tail_q;
  logic [CW-1:0]       count_q;
  logic [PW-1:0]       idx;
  logic                push_ok;
  logic                pop_ok;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign last      = (count_q == CW'(1));
  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];

  // A push into a full queue is legal only while the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) tail_q <= tail_q + PW'(1);
      if (pop_ok)  head_q <= head_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
    end
  end

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_q[idx] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/np_write_buffer.sv
// rtl/np_write_buffer.sv - posted-write buffer between the np core and synchronous memory
module np_write_buffer
  import np_pkg::*;
#(
  parameter int WIDTH    = NP_WIDTH,
  parameter int ADDRSIZE = NP_ADDRSIZE,
  parameter int DEPTH    = NP_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_rd,
  input  logic                cpu_wr,
  input  logic [ADDRSIZE-1:0] cpu_addr,
  input  logic [WIDTH-1:0]    cpu_wdata,
  output logic [WIDTH-1:0]    cpu_rdata,
  output logic                cpu_rvalid,
  output logic                cpu_stall,
  input  logic                flush_req,
  output logic                flush_done,
  output logic                mem_wr,
  output logic [ADDRSIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic [WIDTH-1:0]    mem_rdata,
  output logic                err
);

  np_state_t           state_q;
  logic                full, empty, last, hit;
  logic [ADDRSIZE-1:0] head_addr;
  logic [WIDTH-1:0]    head_data, hit_data;
  logic                push, pop, rd_accept;
  logic                is_rd, is_wr, rd_miss;
  logic                rvalid_q, miss_q, err_q;
  logic [WIDTH-1:0]    rdata_q;

  np_wbuf_fifo #(
    .WIDTH    (WIDTH),
    .ADDRSIZE (ADDRSIZE),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_addr   (cpu_addr),
    .push_data   (cpu_wdata),
    .pop         (pop),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .full        (full),
    .empty       (empty),
    .last        (last),
    .lookup_addr (cpu_addr),
    .hit         (hit),
    .hit_data    (hit_data)
  );

  // A simultaneous load and store is serviced as a load; the store is dropped.
  assign is_rd   = cpu_rd;
  assign is_wr   = cpu_wr & ~cpu_rd;
  assign rd_miss = is_rd & ~hit;

  // Port gated during reset so queued stores never reach memory in that cycle.
  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    rd_accept = 1'b0;
    cpu_stall = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      case (state_q)
        ST_RUN: begin
          pop       = ~empty & (full | ~rd_miss);
          cpu_stall = (rd_miss & full) | (is_wr & full & ~pop);
          rd_accept = is_rd & ~cpu_stall;
          push      = is_wr & ~cpu_stall;
          if (rd_miss && !full) mem_addr = cpu_addr;
        end
        ST_FLUSH: begin
          pop       = ~empty;
          cpu_stall = cpu_rd | cpu_wr;
        end
        default: cpu_stall = cpu_rd | cpu_wr;
      endcase
      if (pop) begin
        mem_wr    = 1'b1;
        mem_addr  = head_addr;
        mem_wdata = head_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      rvalid_q <= 1'b0;
      miss_q   <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rd_accept;
      miss_q   <= rd_accept & ~hit;
      if (rd_accept && hit)       rdata_q <= hit_data;
      else if (rvalid_q && miss_q) rdata_q <= mem_rdata;
      if (cpu_rd && cpu_wr) err_q <= 1'b1;
      case (state_q)
        ST_RUN:   if (flush_req) state_q <= ST_FLUSH;
        ST_FLUSH: if (empty || (last && pop)) state_q <= ST_DONE;
        ST_DONE:  if (!flush_req) state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  // Miss data arrives straight from memory in the valid cycle, then is held locally.
  assign cpu_rdata  = (rvalid_q && miss_q) ? mem_rdata : rdata_q;
  assign cpu_rvalid = rvalid_q;
  assign flush_done = (state_q == ST_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_np_write_buffer.sv
// tb/tb_np_write_buffer.sv - randomized scoreboard bench for np_write_buffer
module tb_np_write_buffer;

  localparam int WIDTH    = 32;
  localparam int ADDRSIZE = 12;
  localparam int DEPTH    = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                cpu_rd, cpu_wr;
  logic [ADDRSIZE-1:0] cpu_addr;
  logic [WIDTH-1:0]    cpu_wdata, cpu_rdata;
  logic                cpu_rvalid, cpu_stall;
  logic                flush_req, flush_done;
  logic                mem_wr;
  logic [ADDRSIZE-1:0] mem_addr;
  logic [WIDTH-1:0]    mem_wdata, mem_rdata;
  logic                err;

  int checks = 0;
  int errors = 0;

  np_write_buffer #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .cpu_stall(cpu_stall), .flush_req(flush_req), .flush_done(flush_done),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int a);
    return (a == 9) ? 32'hDEADBEEF : ((32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Synchronous memory: unwritten words read back a fixed address-derived pattern.
  logic [31:0] mem   [4096];
  bit          wrote [4096];
  always @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_addr]   <= mem_wdata;
      wrote[mem_addr] <= 1'b1;
    end
    mem_rdata <= wrote[mem_addr] ? mem[mem_addr] : init_val(int'(mem_addr));
  end

  // Reference model: pending stores in order, golden memory image, load expectations.
  typedef struct packed {
    logic [ADDRSIZE-1:0] a;
    logic [WIDTH-1:0]    d;
  } ent_t;
  ent_t        pend[$];
  logic [31:0] rd_exp[$];
  logic [31:0] golden [4096];
  int          ms;
  bit          err_m, acc_prev;
  bit          m_full, m_empty, m_rd, m_wr, m_hit, exp_stall, exp_pop;
  logic [31:0] m_hd;
  int          size0;

  initial begin
    for (int i = 0; i < 4096; i++) golden[i] = init_val(i);
    ms = 0; err_m = 0; acc_prev = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("mem_wr_in_reset", mem_wr, 0);
        pend.delete();
        ms = 0; err_m = 0; acc_prev = 0;
      end else begin
        chk("err", err, err_m);
        chk("flush_done", flush_done, ms == 2);
        size0   = pend.size();
        m_full  = (size0 == DEPTH);
        m_empty = (size0 == 0);
        m_rd    = cpu_rd;
        m_wr    = cpu_wr && !cpu_rd;
        m_hit   = 0; m_hd = 0;
        foreach (pend[k]) if (pend[k].a == cpu_addr) begin m_hit = 1; m_hd = pend[k].d; end
        if (ms == 0) begin
          exp_stall = m_rd && !m_hit && m_full;
          exp_pop   = !m_empty && (m_full || !(m_rd && !m_hit));
        end else begin
          exp_stall = cpu_rd || cpu_wr;
          exp_pop   = (ms == 1) && !m_empty;
        end
        chk("cpu_stall", cpu_stall, exp_stall);
        chk("mem_wr", mem_wr, exp_pop);
        if (exp_pop) begin
          chk("mem_addr_drain", mem_addr, pend[0].a);
          chk("mem_wdata_drain", mem_wdata, pend[0].d);
        end else if (ms == 0 && m_rd && !m_hit) begin
          chk("mem_addr_load", mem_addr, cpu_addr);
        end
        acc_prev = (ms == 0) && m_rd && !exp_stall;
        if (acc_prev) rd_exp.push_back(m_hit ? m_hd : golden[cpu_addr]);
        if (exp_pop) begin
          golden[pend[0].a] = pend[0].d;
          void'(pend.pop_front());
        end
        if (ms == 0 && m_wr && !exp_stall) pend.push_back({cpu_addr, cpu_wdata});
        if (cpu_rd && cpu_wr) err_m = 1;
        case (ms)
          0: if (flush_req) ms = 1;
          1: if (size0 <= 1) ms = 2;
          default: if (!flush_req) ms = 0;
        endcase
      end
    end
  end

  // Monitor: a load result must appear exactly one cycle after acceptance.
  initial begin
    forever begin
      @(posedge clk); #3;
      chk("cpu_rvalid", cpu_rvalid, acc_prev);
      if (cpu_rvalid && rd_exp.size() > 0) chk("cpu_rdata", cpu_rdata, rd_exp.pop_front());
    end
  end

  task automatic do_req(input bit rd, input bit wr, input logic [ADDRSIZE-1:0] a,
                        input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      n++;
      if (n > 50) begin
        chk("req_stall_timeout", cpu_stall, 0);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cpu_rd = 0; cpu_wr = 0;
  endtask

  task automatic do_flush();
    int n;
    n = 0;
    flush_req = 1;
    while (!flush_done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("flush_reached_done", flush_done, 1);
    cpu_wr = 1; cpu_addr = 12'd2; cpu_wdata = $urandom;
    @(posedge clk); #1;
    cpu_wr = 0; flush_req = 0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  int r;
  initial begin
    reset = 1; cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; flush_req = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;

    do_req(0, 1, 12'd5, 32'h11111111);
    do_req(1, 0, 12'd5, 32'h0);
    do_req(0, 1, 12'd5, 32'hA);
    do_req(0, 1, 12'd5, 32'hB);
    do_req(1, 0, 12'd5, 32'h0);
    do_req(1, 0, 12'd9, 32'h0);
    for (int i = 0; i < 5; i++) do_req(0, 1, 12'(i + 20), $urandom);
    do_req(0, 1, 12'd6, 32'h1);
    do_req(0, 1, 12'd7, 32'h2);
    do_req(0, 1, 12'd8, 32'h3);
    do_flush();

    do_req(1, 1, 12'd3, 32'h0BAD);
    do_req(0, 1, 12'd11, 32'hCAFE);
    do_req(1, 0, 12'd9, 32'h0);
    pulse_reset();
    do_req(1, 0, 12'd11, 32'h0);
    do_req(1, 0, 12'd3, 32'h0);

    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      do_req(0, 1, 12'($urandom_range(0, 7)), $urandom);
      else if (r < 80) do_req(1, 0, 12'($urandom_range(0, 7)), 32'h0);
      else if (r < 82) do_req(1, 1, 12'($urandom_range(0, 7)), $urandom);
      else if (r < 84) do_flush();
      else if (r < 85) pulse_reset();
      else begin @(posedge clk); #1; end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("loads_outstanding", rd_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
